// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and
// one-entry valid/ready holding register with frame-error and overrun flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic [7:0]       shift, shift_n;
    logic             s1, rx_s;
    logic             good, bad;
    logic             take, load, ovr;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            s1   <= rx;
            rx_s <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        bit_n   = bit_idx;
        shift_n = shift;
        good    = 1'b0;
        bad     = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_TC) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n = DATA;
                        bit_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_TC) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) state_n = STOP;
                    else bit_n = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_TC) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        good    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        bad     = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // A new byte may load into a register that is being drained this edge.
    assign take = rx_valid & rx_ready;
    assign load = good & (~rx_valid | rx_ready);
    assign ovr  = good & rx_valid & ~rx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_valid  <= load | (rx_valid & ~take);
            frame_err <= bad;
            if (load) rx_data <= shift;
            if (ovr) overrun <= 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule
